// File: rtl/branch_flag_controller_pkg.sv
// Shared definitions for the branch/flag controller: condition codes, FSM encoding, flag bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package branch_flag_controller_pkg;

    // Condition codes carried on br_cond
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_LT = 4'd2;
    localparam logic [3:0] COND_GE = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_CS = 4'd8;
    localparam logic [3:0] COND_CC = 4'd9;
    localparam logic [3:0] COND_GT = 4'd10;
    localparam logic [3:0] COND_LE = 4'd11;
    localparam logic [3:0] COND_HI = 4'd12;
    localparam logic [3:0] COND_LS = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        RESOLVE    = 2'd2
    } bfc_state_t;

endpackage

// File: rtl/branch_flag_controller_cond_eval.sv
// Evaluates a 4-bit condition code against the {N,Z,C,V} flag vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond (condition code), flags ({N,Z,C,V}), taken (condition holds).
module branch_flag_controller_cond_eval
    import branch_flag_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n, z, c, v, lt;

    assign n  = flags[FLAG_N];
    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign v  = flags[FLAG_V];
    assign lt = n ^ v;

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_LT: taken = lt;
            COND_GE: taken = !lt;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_GT: taken = !z && !lt;
            COND_LE: taken = z || lt;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_flag_controller.sv
// Holds a conditional branch until in-flight flag writers retire, then resolves it against the flag register.
// Latency: accept at T with nothing pending -> br_done/br_taken/br_pc at T+2; otherwise one cycle after pending count hits 0, plus one.
// Backpressure: br_ready low (stall high) while a branch is outstanding; requester must hold br_req until accepted.
// Ports: issue_setflags/alu_* track and retire flag writers; br_* request/resolve handshake; stall, pend_full, pend_err, flags status.
module branch_flag_controller
    import branch_flag_controller_pkg::*;
#(
    parameter int W        = 32,
    parameter int AW       = 32,
    parameter int MAX_PEND = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_setflags,
    input  logic          alu_valid,
    input  logic          alu_setflags,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_zero,
    input  logic          alu_ovf,
    input  logic          alu_carry,
    input  logic          br_req,
    output logic          br_ready,
    input  logic [3:0]    br_cond,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] br_fallthru,
    output logic          br_done,
    output logic          br_taken,
    output logic [AW-1:0] br_pc,
    output logic          stall,
    output logic          pend_full,
    output logic          pend_err,
    output logic [3:0]    flags
);

    localparam int            CW       = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);

    bfc_state_t    state, state_nxt;
    logic [CW-1:0] pend_cnt, pend_nxt;
    logic          pend_err_set;
    logic          flag_wr;
    logic          latch_en;
    logic [3:0]    cond_q;
    logic [AW-1:0] target_q, fallthru_q;
    logic          cond_taken;
    logic          alu_result_unused;

    // Only the sign bit of the result feeds the flags
    assign alu_result_unused = ^alu_result[W-2:0];

    assign flag_wr   = alu_valid && alu_setflags;
    assign br_ready  = (state == IDLE);
    assign stall     = (state != IDLE);
    assign pend_full = (pend_cnt == PEND_MAX);

    // Pending counter: simultaneous issue and retire cancel; out-of-range moves are dropped and flagged
    always_comb begin
        pend_nxt     = pend_cnt;
        pend_err_set = 1'b0;
        if (issue_setflags && !flag_wr) begin
            if (pend_cnt == PEND_MAX) pend_err_set = 1'b1;
            else                      pend_nxt     = pend_cnt + CW'(1);
        end else if (flag_wr && !issue_setflags) begin
            if (pend_cnt == '0) pend_err_set = 1'b1;
            else                pend_nxt     = pend_cnt - CW'(1);
        end
    end

    // Accepting in IDLE looks at the post-edge count so a same-cycle retire of the
    // last writer lets the branch go straight to RESOLVE.
    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (br_req) begin
                    latch_en  = 1'b1;
                    state_nxt = (pend_nxt == '0) ? RESOLVE : WAIT_FLAGS;
                end
            end
            WAIT_FLAGS: begin
                if (pend_cnt == '0) state_nxt = RESOLVE;
            end
            RESOLVE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    branch_flag_controller_cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (flags),
        .taken (cond_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_cnt   <= '0;
            pend_err   <= 1'b0;
            flags      <= 4'b0000;
            cond_q     <= 4'd0;
            target_q   <= '0;
            fallthru_q <= '0;
            br_done    <= 1'b0;
            br_taken   <= 1'b0;
            br_pc      <= '0;
        end else begin
            state    <= state_nxt;
            pend_cnt <= pend_nxt;
            if (pend_err_set) pend_err <= 1'b1;
            if (flag_wr) begin
                flags[FLAG_N] <= alu_result[W-1];
                flags[FLAG_Z] <= alu_zero;
                flags[FLAG_C] <= alu_carry;
                flags[FLAG_V] <= alu_ovf;
            end
            if (latch_en) begin
                cond_q     <= br_cond;
                target_q   <= br_target;
                fallthru_q <= br_fallthru;
            end
            br_done <= (state == RESOLVE);
            if (state == RESOLVE) begin
                br_taken <= cond_taken;
                br_pc    <= cond_taken ? target_q : fallthru_q;
            end
        end
    end

endmodule

// File: tb/tb_branch_flag_controller.sv
module tb_branch_flag_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_setflags;
    logic        alu_valid;
    logic        alu_setflags;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_carry;
    logic        br_req;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_target;
    logic [31:0] br_fallthru;
    logic        br_done;
    logic        br_taken;
    logic [31:0] br_pc;
    logic        stall;
    logic        pend_full;
    logic        pend_err;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_flag_controller #(.W(32), .AW(32), .MAX_PEND(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_setflags (issue_setflags),
        .alu_valid      (alu_valid),
        .alu_setflags   (alu_setflags),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .alu_ovf        (alu_ovf),
        .alu_carry      (alu_carry),
        .br_req         (br_req),
        .br_ready       (br_ready),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .br_fallthru    (br_fallthru),
        .br_done        (br_done),
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .stall          (stall),
        .pend_full      (pend_full),
        .pend_err       (pend_err),
        .flags          (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) begin
            issue_setflags = 1'b1;
            tick();
        end
        issue_setflags = 1'b0;
    endtask

    task automatic retire(input logic [31:0] r, input logic z, input logic c, input logic v);
        alu_valid    = 1'b1;
        alu_setflags = 1'b1;
        alu_result   = r;
        alu_zero     = z;
        alu_carry    = c;
        alu_ovf      = v;
        tick();
        alu_valid    = 1'b0;
        alu_setflags = 1'b0;
    endtask

    // Presents a request for one edge; caller only uses this when br_ready is high
    task automatic request(input logic [3:0] c, input logic [31:0] tgt, input logic [31:0] ft);
        br_req      = 1'b1;
        br_cond     = c;
        br_target   = tgt;
        br_fallthru = ft;
        tick();
        br_req      = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            tick();
            if (br_done === 1'b1) got = 1'b1;
        end
        check(tag, got, 1);
    endtask

    // Odd codes are the inverse of the even code below them
    function automatic bit model(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = n ^ v;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy;
            3'd5: base = !z && !(n ^ v);
            3'd6: base = cy && !z;
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    initial begin
        bit         seen;
        logic [3:0] pat;
        logic [3:0] cc;
        logic [31:0] tgt, ft;
        bit         exp_t;

        rst_n = 1'b0;
        issue_setflags = 0; alu_valid = 0; alu_setflags = 0; alu_result = 0;
        alu_zero = 0; alu_ovf = 0; alu_carry = 0;
        br_req = 0; br_cond = 0; br_target = 0; br_fallthru = 0;

        // Reset state
        #12;
        check("rst_flags", flags, 4'h0);
        check("rst_done", br_done, 0);
        check("rst_taken", br_taken, 0);
        check("rst_pc", br_pc, 0);
        check("rst_ready", br_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_full", pend_full, 0);
        check("rst_err", pend_err, 0);
        #5 rst_n = 1'b1;
        tick();

        // Reset while waiting on two writers abandons the branch
        issue(2);
        request(4'd14, 32'h200, 32'h10);
        check("midwait_stall", stall, 1);
        check("midwait_ready", br_ready, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_ready", br_ready, 1);
        check("midrst_done", br_done, 0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (br_done === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", seen, 0);

        // EQ with Z set, nothing pending: done at T+2
        issue(1);
        retire(32'h0, 1'b1, 1'b0, 1'b0);
        check("eq_flags", flags, 4'b0100);
        request(4'd0, 32'h100, 32'h44);
        check("eq_t1_stall", stall, 1);
        check("eq_t1_done", br_done, 0);
        tick();
        check("eq_t2_done", br_done, 1);
        check("eq_taken", br_taken, 1);
        check("eq_pc", br_pc, 32'h100);
        check("eq_t2_ready", br_ready, 1);
        tick();
        check("eq_done_pulse", br_done, 0);
        check("eq_pc_hold", br_pc, 32'h100);

        // LT waits for two writers; last one sets N
        issue(2);
        request(4'd2, 32'h300, 32'h80);
        check("lt_stall0", stall, 1);
        tick(); tick();
        check("lt_stall1", stall, 1);
        check("lt_nodone1", br_done, 0);
        retire(32'h5, 1'b0, 1'b0, 1'b0);
        check("lt_flags1", flags, 4'b0000);
        check("lt_stall2", stall, 1);
        tick();
        check("lt_stall3", stall, 1);
        retire(32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
        check("lt_flags2", flags, 4'b1000);
        wait_done(6, "lt_done");
        check("lt_taken", br_taken, 1);
        check("lt_pc", br_pc, 32'h300);

        // Same-cycle issue and retire at count 1 keeps the branch waiting
        issue(1);
        request(4'd0, 32'h400, 32'h90);
        issue_setflags = 1'b1;
        retire(32'h0, 1'b1, 1'b0, 1'b0);
        issue_setflags = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (br_done === 1'b1) seen = 1'b1;
        end
        check("same_no_done", seen, 0);
        check("same_stall", stall, 1);
        retire(32'h7, 1'b0, 1'b0, 1'b0);
        wait_done(6, "same_done");
        check("same_taken", br_taken, 0);
        check("same_pc", br_pc, 32'h90);

        // Overflow and underflow of the pending counter
        issue(3);
        check("full_at3", pend_full, 1);
        check("err_before", pend_err, 0);
        issue(1);
        check("full_ovf", pend_full, 1);
        check("err_ovf", pend_err, 1);
        retire(32'h1, 1'b0, 1'b0, 1'b0);
        check("full_after_ret", pend_full, 0);
        retire(32'h1, 1'b0, 1'b0, 1'b0);
        retire(32'h1, 1'b0, 1'b0, 1'b0);
        retire(32'h1, 1'b0, 1'b0, 1'b0);
        check("err_sticky", pend_err, 1);
        check("full_empty", pend_full, 0);
        request(4'd14, 32'h500, 32'hA0);
        tick();
        check("uf_t2_done", br_done, 1);
        check("uf_pc", br_pc, 32'h500);

        // Reset clears sticky error and latched outputs
        #2 rst_n = 1'b0;
        #1;
        check("rst2_err", pend_err, 0);
        check("rst2_pc", br_pc, 0);
        check("rst2_taken", br_taken, 0);
        check("rst2_flags", flags, 4'h0);
        #1 rst_n = 1'b1;
        tick();

        // Every code over every flag pattern
        for (int p = 0; p < 16; p++) begin
            pat = 4'(p);
            issue(1);
            retire(pat[3] ? 32'h8000_0000 : 32'h0000_1234, pat[2], pat[1], pat[0]);
            check("sweep_flags", flags, pat);
            for (int c = 0; c < 16; c++) begin
                cc    = 4'(c);
                tgt   = 32'h1_0000 + (p << 8) + (c << 2);
                ft    = 32'h2_0000 + (p << 8) + (c << 2);
                exp_t = model(cc, pat);
                request(cc, tgt, ft);
                tick();
                check("sweep_done", br_done, 1);
                check("sweep_taken", br_taken, exp_t);
                check("sweep_pc", br_pc, exp_t ? tgt : ft);
            end
        end
        check("sweep_err", pend_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_flag_controller.md
Name: branch_flag_controller

Overview:
- Sequences conditional branches against the processor status flags (Z, N, V, C).
- Owns the architectural flag register and tracks flag-setting ALU operations still in flight.
- Holds a branch request until all in-flight flag writers have retired, then evaluates the 4-bit condition code and issues a resolved next-PC with a one-cycle done pulse.
- Sits between decode/fetch and the ALU; asserts stall while a branch is outstanding.

Parameters:
- W, 32, ALU result width; N flag is bit W-1.
- AW, 32, PC/target address width.
- MAX_PEND, 3, maximum in-flight flag-setting ops; counter width is clog2(MAX_PEND+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_setflags  in  1  decode issued a flag-setting op this cycle.
- alu_valid  in  1  ALU result valid this cycle.
- alu_setflags  in  1  valid ALU op updates flags.
- alu_result  in  W  ALU result.
- alu_zero  in  1  ALU zero output.
- alu_ovf  in  1  ALU signed overflow.
- alu_carry  in  1  ALU carry out.
- br_req  in  1  branch request.
- br_ready  out  1  controller can accept a branch.
- br_cond  in  4  condition code.
- br_target  in  AW  taken target.
- br_fallthru  in  AW  not-taken PC (PC+4).
- br_done  out  1  one-cycle resolution pulse.
- br_taken  out  1  resolved direction; valid with br_done.
- br_pc  out  AW  next PC; valid with br_done.
- stall  out  1  high while a branch is accepted but unresolved.
- pend_full  out  1  pending counter equals MAX_PEND.
- pend_err  out  1  sticky underflow/overflow error.
- flags  out  4  {N,Z,C,V} registered flag state.

Behaviour:
- Reset (async, rst_n=0):
  - flags=0, pend_cnt=0, state=IDLE, br_done=0, br_taken=0, br_pc=0, pend_err=0.
  - Latched cond/target/fallthru are cleared.
  - Reset mid-branch abandons the branch; no br_done is emitted.
- Flag register:
  - Updates on posedge when alu_valid && alu_setflags.
  - N=alu_result[W-1], Z=alu_zero, C=alu_carry, V=alu_ovf.
  - Holds its value otherwise.
- Pending counter:
  - Increments on issue_setflags.
  - Decrements on alu_valid && alu_setflags.
  - Both in the same cycle: counter unchanged.
  - Increment while at MAX_PEND: ignored, pend_err set.
  - Decrement at 0: ignored, pend_err set.
  - pend_err clears only on reset.
- FSM states IDLE, WAIT_FLAGS, RESOLVE:
  - br_ready = (state==IDLE). stall = (state!=IDLE).
  - IDLE: on br_req && br_ready, latch br_cond, br_target, br_fallthru.
    - Next state is RESOLVE if next-cycle pend_cnt==0, otherwise WAIT_FLAGS.
    - Next-cycle pend_cnt includes any same-cycle increment or decrement.
  - WAIT_FLAGS: go to RESOLVE in the cycle after pend_cnt reaches 0. The registered flags then reflect the last writer.
  - RESOLVE: evaluate using registered flags.
    - br_done=1, br_taken=cond result.
    - br_pc = taken ? target : fallthru.
    - Return to IDLE.
    - br_done, br_taken and br_pc are registered outputs, visible the cycle after RESOLVE is entered.
    - br_done is 0 in all other cycles; br_taken and br_pc hold their last values.
- Latency: accept at cycle T with no pending ops gives br_done at T+2.
- A new request is accepted no earlier than the cycle br_done is high (FSM already IDLE).
- Condition codes:
  - 0 EQ Z; 1 NE !Z.
  - 2 LT N^V; 3 GE !(N^V).
  - 4 MI N; 5 PL !N.
  - 6 VS V; 7 VC !V.
  - 8 CS C; 9 CC !C.
  - 10 GT !Z&&!(N^V); 11 LE Z||(N^V).
  - 12 HI C&&!Z; 13 LS !C||Z.
  - 14 AL 1; 15 NV 0.
- br_req while not ready is ignored; the requester must hold it.

Decomposition:
- Shared package holds:
  - condition-code localparams (COND_EQ..COND_NV);
  - FSM state encoding (2 bits);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One combinational sub-module, cond_eval: inputs cond[3:0] and flags[3:0], output taken.

Test Plan:
- Reset mid-WAIT_FLAGS (pend_cnt=2) -> outputs zero, br_ready=1 immediately, no br_done after release.
- No pending; ALU writes result 0x0, zero=1; branch cond=EQ, target=0x100, fallthru=0x44 -> br_done at T+2, br_taken=1, br_pc=0x100.
- issue_setflags twice; branch LT requested; ALU retires 0x5 then 0xFFFFFFF0 (ovf=0) -> stall held until second retire, then br_taken=1, flags N=1.
- Same-cycle issue_setflags and retire with pend_cnt=1 -> counter stays 1 and the branch keeps waiting.
- Fill to MAX_PEND=3, issue again -> pend_full=1, pend_err=1, counter stays 3. Retire at 0 -> pend_err stays 1.
- Sweep all 16 codes over all 16 flag patterns -> br_taken matches the table. NV never taken, AL always taken with br_pc=target.
